// File: rtl/aura16_pkg.sv
// rtl/aura16_pkg.sv - shared constants and FSM state type for the aura16 fetch path
package aura16_pkg;

  localparam int          DEPTH = 512;
  localparam int          AW    = 9;
  localparam logic [15:0] NOP   = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory loader and single-cycle fetch stage
module imem_fetch_ctrl #(
  parameter int          DEPTH = aura16_pkg::DEPTH,
  parameter int          AW    = aura16_pkg::AW,
  parameter logic [15:0] NOP   = aura16_pkg::NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic        run_en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [1:0]  state
);
  import aura16_pkg::*;

  fsm_state_t    cur_st;
  fsm_state_t    nxt_st;
  logic [AW-1:0] load_ptr;
  logic [15:0]   pc;
  logic          st_load;
  logic          st_run;
  logic          load_last;
  logic          load_exit;

  // Anything that is neither LOAD nor RUN behaves as IDLE, including the unused encoding.
  assign st_load   = (cur_st == ST_LOAD);
  assign st_run    = (cur_st == ST_RUN);
  assign load_last = (load_ptr == AW'(DEPTH - 1));
  assign load_exit = st_load && (!load_en || (load_valid && load_last));
  assign state     = cur_st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  always_comb begin
    nxt_st     = cur_st;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = load_data;
    case (cur_st)
      ST_LOAD: begin
        // Gated by rst_n so a reset landing mid-load never commits a write.
        load_ready = rst_n;
        mem_we     = rst_n && load_valid;
        mem_addr   = {{(16 - AW){1'b0}}, load_ptr};
        if (load_exit) nxt_st = ST_IDLE;
      end
      ST_RUN: begin
        if (load_en) nxt_st = ST_IDLE;
      end
      default: begin
        if (load_en)     nxt_st = ST_LOAD;
        else if (run_en) nxt_st = ST_RUN;
        else             nxt_st = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_ptr <= '0;
      pc       <= 16'h0000;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= 16'h0000;
    end else begin
      if (!st_load && !st_run && load_en) begin
        load_ptr <= '0;
      end else if (st_load && load_valid && !load_last) begin
        load_ptr <= load_ptr + 1'b1;
      end

      if (load_exit) pc <= 16'h0000;

      // Leaving RUN for a reload outranks redirect, which outranks stall.
      if (st_run) begin
        if (load_en) begin
          if_valid <= 1'b0;
          if_instr <= NOP;
        end else if (redirect_valid) begin
          pc       <= redirect_addr;
          if_valid <= 1'b0;
          if_instr <= NOP;
        end else if (!stall) begin
          if_instr <= mem_rdata;
          if_pc    <= pc;
          if_valid <= 1'b1;
          pc       <= pc + 16'd1;
        end
      end
    end
  end

endmodule
